plru_way_ctrl: RTL

PLRU_WAY_CTRL -- requirements
Module: plru_way_ctrl

---
 rtl/l2_cache_pkg.sv | 27 ++
 rtl/way_encoder.sv | 25 ++
 rtl/plru_way_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/l2_cache_pkg.sv
// Shared types and sizing for the L2 replacement controller.
// Op and FSM encodings are fixed so checkers can decode them from raw bits.
package l2_cache_pkg;

    typedef enum logic [1:0] {
        OP_TOUCH = 2'd0,
        OP_ALLOC = 2'd1,
        OP_CLEAR = 2'd2,
        OP_RSVD  = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_UPDATE = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam int DEF_WAYS = 8;
    localparam int DEF_SETS = 16;

    // A binary tree over WAYS leaves has WAYS-1 internal nodes.
    function automatic int plru_bits(input int ways);
        return ways - 1;
    endfunction

endpackage

// File: rtl/way_encoder.sv
// One-hot to binary index encoder with a flag that is set only when
// exactly one input bit is high.
module way_encoder #(
    parameter int WAYS = 8
) (
    input  logic [WAYS-1:0]         vec_i,
    output logic [$clog2(WAYS)-1:0] idx_o,
    output logic                    onehot_ok_o
);

    localparam int WAY_W = $clog2(WAYS);

    always_comb begin
        idx_o = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (vec_i[i]) begin
                idx_o = idx_o | WAY_W'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves zero only for a power of two.
    assign onehot_ok_o = (vec_i != '0) && ((vec_i & (vec_i - 1'b1)) == '0);

endmodule

// File: rtl/plru_way_ctrl.sv
// Per-set tree-PLRU replacement controller: touch, allocate and clear
// requests run through a fixed IDLE/READ/UPDATE/RESP pipeline.
module plru_way_ctrl
    import l2_cache_pkg::*;
#(
    parameter int WAYS = DEF_WAYS,
    parameter int SETS = DEF_SETS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [1:0]              req_op,
    input  logic [$clog2(SETS)-1:0] req_set,
    input  logic [WAYS-1:0]         req_hit_vec,
    input  logic [WAYS-1:0]         req_valid_vec,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(WAYS)-1:0] rsp_way,
    output logic                    rsp_err,
    output logic [1:0]              dbg_state
);

    localparam int WAY_W     = $clog2(WAYS);
    localparam int SET_W     = $clog2(SETS);
    localparam int PLRU_BITS = plru_bits(WAYS);

    // Handshake rule for both channels: a transfer happens on a rising edge
    // where valid && ready; the request side is ready only in IDLE, and the
    // response payload is held unchanged until its transfer edge.

    state_t                 state_q;
    logic                   req_ready_q;
    logic                   rsp_valid_q;
    logic [WAY_W-1:0]       rsp_way_q;
    logic                   rsp_err_q;
    op_t                    op_q;
    logic [SET_W-1:0]       set_q;
    logic [WAYS-1:0]        valid_vec_q;
    logic [WAY_W-1:0]       hit_idx_q;
    logic                   hit_ok_q;
    logic [PLRU_BITS-1:0]   row_q;
    logic [PLRU_BITS-1:0]   plru_q [SETS];

    logic [WAY_W-1:0]       enc_idx;
    logic                   enc_ok;

    logic [PLRU_BITS-1:0]   upd_row_d;
    logic [WAY_W-1:0]       upd_way_d;
    logic                   upd_err_d;
    logic                   upd_wr_d;

    way_encoder #(
        .WAYS (WAYS)
    ) u_hit_enc (
        .vec_i       (req_hit_vec),
        .idx_o       (enc_idx),
        .onehot_ok_o (enc_ok)
    );

    // Node n lives at tree[n]; tree[0] and the leaf half are padding so the
    // walk can index by node number directly.
    function automatic logic [WAY_W-1:0] tree_victim(input logic [PLRU_BITS-1:0] row);
        logic [2*WAYS-1:0] tree;
        logic [WAY_W:0]    node;
        tree = {{WAYS{1'b0}}, row, 1'b0};
        node = (WAY_W+1)'(1);
        for (int l = 0; l < WAY_W; l++) begin
            node = {node[WAY_W-1:0], tree[node]};
        end
        return node[WAY_W-1:0];
    endfunction

    // Each ancestor of leaf WAYS+way is made to point at the sibling subtree.
    function automatic logic [PLRU_BITS-1:0] touch_row(input logic [PLRU_BITS-1:0] row,
                                                       input logic [WAY_W-1:0]     way);
        logic [2*WAYS-1:0] tree;
        logic [WAY_W:0]    leaf;
        tree = {{WAYS{1'b0}}, row, 1'b0};
        leaf = {1'b1, way};
        for (int k = 1; k <= WAY_W; k++) begin
            tree[leaf >> k] = ~leaf[k-1];
        end
        return tree[PLRU_BITS:1];
    endfunction

    function automatic logic [WAY_W-1:0] lowest_invalid(input logic [WAYS-1:0] vv);
        logic [WAY_W-1:0] sel;
        sel = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!vv[i]) begin
                sel = WAY_W'(i);
            end
        end
        return sel;
    endfunction

    always_comb begin
        upd_row_d = row_q;
        upd_way_d = '0;
        upd_err_d = 1'b0;
        upd_wr_d  = 1'b0;
        case (op_q)
            OP_TOUCH: begin
                if (hit_ok_q) begin
                    upd_way_d = hit_idx_q;
                    upd_row_d = touch_row(row_q, hit_idx_q);
                    upd_wr_d  = 1'b1;
                end else begin
                    upd_err_d = 1'b1;
                end
            end
            OP_ALLOC: begin
                upd_way_d = (&valid_vec_q) ? tree_victim(row_q) : lowest_invalid(valid_vec_q);
                upd_row_d = touch_row(row_q, upd_way_d);
                upd_wr_d  = 1'b1;
            end
            OP_CLEAR: begin
                upd_row_d = '0;
                upd_wr_d  = 1'b1;
            end
            default: begin
                upd_err_d = 1'b1;
            end
        endcase
    end

    // Only the addressed row is written, and only from UPDATE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                plru_q[s] <= '0;
            end
        end else if (state_q == ST_UPDATE && upd_wr_d) begin
            plru_q[set_q] <= upd_row_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_way_q   <= '0;
            rsp_err_q   <= 1'b0;
            op_q        <= OP_TOUCH;
            set_q       <= '0;
            valid_vec_q <= '0;
            hit_idx_q   <= '0;
            hit_ok_q    <= 1'b0;
            row_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q        <= op_t'(req_op);
                        set_q       <= req_set;
                        valid_vec_q <= req_valid_vec;
                        hit_idx_q   <= enc_idx;
                        hit_ok_q    <= enc_ok;
                        req_ready_q <= 1'b0;
                        state_q     <= ST_READ;
                    end
                end
                ST_READ: begin
                    // Reading after the previous UPDATE edge means no bypass is needed.
                    row_q   <= plru_q[set_q];
                    state_q <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    rsp_way_q   <= upd_way_d;
                    rsp_err_q   <= upd_err_d;
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_way   = rsp_way_q;
    assign rsp_err   = rsp_err_q;
    assign dbg_state = state_q;

endmodule
